// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared types and constants for the RAM responder
package ram_pkg;

  typedef enum logic [1:0] {RS_IDLE, RS_ACCESS, RS_DONE} ramState_t;

  localparam logic [31:0] BAD_DATA = 32'hBAD1_BAD1;
  localparam int          LAT_MIN  = 1;
  localparam int          LAT_MAX  = 15;

  function automatic bit latency_legal(input int lat);
    return (lat >= LAT_MIN) && (lat <= LAT_MAX);
  endfunction

endpackage

// File: rtl/ram_array.sv
// rtl/ram_array.sv - single-port word SRAM, synchronous write and synchronous read
module ram_array #(
  parameter int ADDR_BITS = 10,
  parameter     INIT_FILE = ""
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [ADDR_BITS-1:0] addr_i,
  input  logic [31:0]          wdata_i,
  output logic [31:0]          rdata_o
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_responder.sv
// rtl/ram_responder.sv - request FSM with wait-state counter in front of ram_array
module ram_responder
  import ram_pkg::*;
#(
  parameter int LATENCY   = 2,
  parameter int ADDR_BITS = 10,
  parameter     INIT_FILE = ""
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Ren,
  input  logic        Wen,
  input  logic [31:0] ramaddr,
  input  logic [31:0] ramstore,
  output logic [31:0] ramload,
  output logic        busy_o
);

  if (!latency_legal(LATENCY)) begin : g_bad_latency
    $error("ram_responder: LATENCY must be within 1..15");
  end

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  ramState_t   state_q;
  logic [3:0]  cnt_q;
  logic        wr_q;
  logic [31:2] addr_q;
  logic [31:0] data_q;
  logic [31:0] ramload_q;
  logic        busy_q;

  logic                 in_range;
  logic                 access_now;
  logic                 mem_we;
  logic [ADDR_BITS-1:0] arr_addr_d;
  logic [31:0]          arr_rdata;
  logic                 unused_low_bits;

  assign unused_low_bits = ^ramaddr[1:0];

  assign in_range   = (addr_q[31:ADDR_BITS+2] == '0);
  assign access_now = (state_q == RS_ACCESS) && (cnt_q == 4'd0);
  assign mem_we     = access_now && wr_q && in_range;

  // In IDLE the array reads the live address so that LATENCY=1 already has
  // a read result at the completing edge; afterwards the latched address.
  always_comb begin
    arr_addr_d = addr_q[ADDR_BITS+1:2];
    if (state_q == RS_IDLE) begin
      arr_addr_d = ramaddr[ADDR_BITS+1:2];
    end
  end

  ram_array #(
    .ADDR_BITS (ADDR_BITS),
    .INIT_FILE (INIT_FILE)
  ) u_array (
    .clk_i   (CLK),
    .we_i    (mem_we),
    .addr_i  (arr_addr_d),
    .wdata_i (data_q),
    .rdata_o (arr_rdata)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= RS_IDLE;
      cnt_q     <= 4'd0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= 32'd0;
      ramload_q <= 32'd0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        RS_IDLE: begin
          if (Ren || Wen) begin
            wr_q    <= Wen;
            addr_q  <= ramaddr[31:2];
            data_q  <= ramstore;
            cnt_q   <= CNT_LOAD;
            busy_q  <= 1'b1;
            state_q <= RS_ACCESS;
          end
        end
        RS_ACCESS: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            if (!wr_q) begin
              ramload_q <= in_range ? arr_rdata : BAD_DATA;
            end
            busy_q  <= 1'b0;
            state_q <= RS_DONE;
          end
        end
        RS_DONE: begin
          state_q <= RS_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= RS_IDLE;
        end
      endcase
    end
  end

  assign ramload = ramload_q;
  assign busy_o  = busy_q;

endmodule

// File: tb/tb_ram_responder.sv
// tb/tb_ram_responder.sv - scoreboard bench for ram_responder with a word-array reference model
module tb_ram_responder;

  localparam int LATENCY   = 2;
  localparam int ADDR_BITS = 10;
  localparam logic [31:0] BAD = 32'hBAD1_BAD1;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        Ren = 1'b1;
  logic        Wen = 1'b0;
  logic [31:0] ramaddr = 32'd0;
  logic [31:0] ramstore = 32'd0;
  logic [31:0] ramload;
  logic        busy_o;

  ram_responder #(.LATENCY(LATENCY), .ADDR_BITS(ADDR_BITS), .INIT_FILE("")) dut (
    .CLK(CLK), .RST(RST), .Ren(Ren), .Wen(Wen), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .busy_o(busy_o)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] exp_q[$];
  logic [31:0] model_mem [int];
  logic [31:0] last_load = 32'd0;
  bit          mon_hold = 1'b0;
  logic [31:0] pool [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic bit model_in_range(input logic [31:0] a);
    return {32'd0, a} < (64'd1 << (ADDR_BITS + 2));
  endfunction

  // Reference: word-addressed memory with write priority and a sticky last-read value.
  function automatic logic [31:0] model_op(input bit w, input bit r, input logic [31:0] a,
                                           input logic [31:0] d);
    int idx;
    idx = int'(a / 4);
    if (w) begin
      if (model_in_range(a)) model_mem[idx] = d;
      return last_load;
    end
    if (model_in_range(a)) last_load = model_mem.exists(idx) ? model_mem[idx] : 32'hxxxx_xxxx;
    else last_load = BAD;
    return last_load;
  endfunction

  // Monitor: a busy_o falling edge outside reset marks a DONE cycle.
  bit prev_busy = 1'b0;
  int busy_run  = 0;
  always @(negedge CLK) begin
    if (RST || mon_hold) begin
      prev_busy = 1'b0;
      busy_run  = 0;
    end else begin
      if (busy_o) begin
        busy_run++;
      end else if (prev_busy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          chk("done_ramload", ramload, exp_q.pop_front());
          chk("busy_len", 32'(busy_run), 32'(LATENCY));
        end
        busy_run = 0;
      end
      prev_busy = busy_o;
    end
  end

  // scr: 0 quiet during access, 1 retarget to 0x24 with Wen, 2 random noise
  task automatic issue(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d,
                       input int scr);
    @(negedge CLK);
    Wen = w; Ren = r; ramaddr = a; ramstore = d;
    exp_q.push_back(model_op(w, r, a, d));
    @(negedge CLK);
    if (scr == 1) begin
      Wen = 1'b1; Ren = 1'b0; ramaddr = 32'h24; ramstore = $urandom;
    end else begin
      Wen = 1'b0; Ren = 1'b0;
    end
    for (int k = 0; k < LATENCY + 1; k++) begin
      if (scr == 2) begin
        Wen = 1'($urandom); Ren = 1'($urandom); ramaddr = $urandom; ramstore = $urandom;
      end
      @(negedge CLK);
    end
    Wen = 1'b0; Ren = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    int sel;

    // Reset held with a pending read request
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("reset_busy", {31'd0, busy_o}, 32'd0);
      chk("reset_ramload", ramload, 32'd0);
    end
    Ren = 1'b0;
    RST = 1'b0;

    pool[0] = 32'h10; pool[1] = 32'h20; pool[2] = 32'h24; pool[3] = 32'h30;
    pool[4] = 32'h678;
    for (int i = 5; i < 16; i++) pool[i] = {20'd0, $urandom_range(0, 1023), 2'b00};
    for (int i = 0; i < 16; i++) issue(1'b1, 1'b0, pool[i], $urandom, 0);

    issue(1'b1, 1'b0, 32'h10, 32'h1234_1234, 0);
    issue(1'b0, 1'b1, 32'h10, 32'h0, 0);
    issue(1'b1, 1'b1, 32'h20, 32'h4321_4321, 0);
    issue(1'b0, 1'b1, 32'h20, 32'h0, 0);
    issue(1'b0, 1'b1, 32'h10, 32'h0, 1);
    issue(1'b0, 1'b1, 32'h24, 32'h0, 0);
    issue(1'b0, 1'b1, 32'hABCD_ABCD, 32'h0, 0);
    issue(1'b1, 1'b0, 32'h5678_5678, 32'hDEAD_BEEF, 0);
    issue(1'b0, 1'b1, 32'h5678_5678 & 32'h0000_0FFC, 32'h0, 0);
    issue(1'b0, 1'b1, 32'h13, 32'h0, 0);

    // Reset during ACCESS drops the pending write
    @(negedge CLK);
    Wen = 1'b1; ramaddr = 32'h30; ramstore = 32'h2222_2222;
    @(negedge CLK);
    Wen = 1'b0;
    mon_hold = 1'b1;
    RST = 1'b1;
    #1;
    chk("rst_mid_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_mid_ramload", ramload, 32'd0);
    last_load = 32'd0;
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    #2 mon_hold = 1'b0;
    issue(1'b0, 1'b1, 32'h30, 32'h0, 0);

    // Continuously held read: accepted every LATENCY+2 edges
    @(negedge CLK);
    Ren = 1'b1; ramaddr = 32'h20;
    for (int i = 0; i < 3; i++) exp_q.push_back(model_op(1'b0, 1'b1, 32'h20, 32'h0));
    repeat (3 * (LATENCY + 2) - 1) @(negedge CLK);
    Ren = 1'b0;
    repeat (LATENCY + 2) @(negedge CLK);

    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 9);
      a = pool[$urandom_range(0, 15)] | 32'($urandom_range(0, 3));
      d = $urandom;
      case (sel)
        0, 1, 2, 3: issue(1'b0, 1'b1, a, d, 2);
        4, 5, 6:    issue(1'b1, 1'b0, a, d, 2);
        7:          issue(1'b0, 1'b1, $urandom | 32'h0000_1000, d, 2);
        8:          issue(1'b1, 1'b0, $urandom | 32'h0000_1000, d, 2);
        default:    issue(1'b1, 1'b1, a, d, 2);
      endcase
    end

    repeat (LATENCY + 4) @(negedge CLK);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
